// File: rtl/vga_timing_gen.sv
// Raster timing source: free-running hcount/vcount with sync/blank decode and base rgb.
// Define VGA_TEST_PATTERN_EN to replace the black base colour with 8 vertical colour bars.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BP      = 88,
  parameter int unsigned V_ACTIVE  = 600,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BP      = 23,
  parameter bit          HSYNC_POL = 1'b1,
  parameter bit          VSYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        restart_i,
  output logic        frame_start_o,
  output logic        line_start_o,
  output logic [10:0] hcount_o,
  output logic [10:0] vcount_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        hblnk_o,
  output logic        vblnk_o,
  output logic [11:0] rgb_o
);

  localparam int unsigned CW      = 11;
  localparam int unsigned RGBW    = 12;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HB_START = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VB_START = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          hblnk_q, hblnk_d;
  logic          vblnk_q, vblnk_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          advance_c;

  // restart wins over a held raster; otherwise the raster only moves when enabled
  assign advance_c = en_i | restart_i;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (restart_i) begin
      hcount_d = '0;
      vcount_d = '0;
    end else if (en_i) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CW'(1);
      end else begin
        hcount_d = hcount_q + CW'(1);
      end
    end
  end

  // Decode from the next counter values so every field lands with its counter
  always_comb begin
    hblnk_d       = (hcount_d >= HB_START);
    vblnk_d       = (vcount_d >= VB_START);
    hsync_d       = ((hcount_d >= HS_START) && (hcount_d <= HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = ((vcount_d >= VS_START) && (vcount_d <= VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    line_start_d  = advance_c && (hcount_d == '0);
    frame_start_d = advance_c && (hcount_d == '0) && (vcount_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign hblnk_o       = hblnk_q;
  assign vblnk_o       = vblnk_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned BCW   = $clog2(BAR_W + 1);
  localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);

  logic [BCW-1:0]  bar_cnt_q, bar_cnt_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic [RGBW-1:0] rgb_q, rgb_d;

  function automatic logic [RGBW-1:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 12'hFFF;
      3'd1:    bar_colour = 12'hFF0;
      3'd2:    bar_colour = 12'h0FF;
      3'd3:    bar_colour = 12'h0F0;
      3'd4:    bar_colour = 12'hF0F;
      3'd5:    bar_colour = 12'hF00;
      3'd6:    bar_colour = 12'h00F;
      default: bar_colour = 12'h000;
    endcase
  endfunction

  // Bar position tracks the next hcount: cleared at line start, stepped per pixel
  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    rgb_d     = rgb_q;
    if (hcount_d == '0) begin
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else if (en_i) begin
      if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + BCW'(1);
      end
    end
    if (advance_c) begin
      rgb_d = (hblnk_d || vblnk_d) ? '0 : bar_colour(bar_idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      rgb_q     <= '0;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      rgb_q     <= rgb_d;
    end
  end

  assign rgb_o = rgb_q;
`else
  assign rgb_o = RGBW'(0);
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: per-cycle scoreboard model plus a table of
// fixed raster checkpoints. Vertical timing is shrunk so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned H_FP     = 40;
  localparam int unsigned H_SYNC   = 128;
  localparam int unsigned H_BP     = 88;
  localparam int unsigned V_ACTIVE = 10;
  localparam int unsigned V_FP     = 1;
  localparam int unsigned V_SYNC   = 4;
  localparam int unsigned V_BP     = 5;
  localparam int H_TOTAL = 1056;
  localparam int V_TOTAL = 20;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic        ls;
    logic        fs;
  } obs_t;

  typedef struct {
    int   cycles;
    logic en;
    logic rs;
    obs_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_i;
  logic        restart_i;
  logic        frame_start_o;
  logic        line_start_o;
  logic [10:0] hcount_o;
  logic [10:0] vcount_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        hblnk_o;
  logic        vblnk_o;
  logic [11:0] rgb_o;

  int checks   = 0;
  int failures = 0;

  int   mh, mv;
  logic m_ls, m_fs, m_fresh;
  obs_t sb_q[$];
  vec_t vecs[$];

  localparam logic [11:0] PAL [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                        12'hF0F, 12'hF00, 12'h00F, 12'h000};

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .restart_i(restart_i),
    .frame_start_o(frame_start_o), .line_start_o(line_start_o),
    .hcount_o(hcount_o), .vcount_o(vcount_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o),
    .hblnk_o(hblnk_o), .vblnk_o(vblnk_o), .rgb_o(rgb_o)
  );

  always #5 clk = ~clk;

  function automatic obs_t dut_obs();
    obs_t o;
    o.h = hcount_o; o.v = vcount_o; o.hs = hsync_o; o.vs = vsync_o;
    o.hb = hblnk_o; o.vb = vblnk_o; o.rgb = rgb_o;
    o.ls = line_start_o; o.fs = frame_start_o;
    return o;
  endfunction

  function automatic obs_t mk(int h, int v, logic hs, logic vs, logic hb, logic vb,
                              logic ls, logic fs, logic [11:0] rgb);
    obs_t o;
    o.h = 11'(h); o.v = 11'(v); o.hs = hs; o.vs = vs; o.hb = hb; o.vb = vb;
    o.ls = ls; o.fs = fs;
`ifdef VGA_TEST_PATTERN_EN
    o.rgb = rgb;
`else
    o.rgb = (rgb == 12'h000) ? 12'h000 : 12'h000;
`endif
    return o;
  endfunction

  // Reference expectation from raster position, written as plain interval tests
  function automatic obs_t model_obs();
    logic [11:0] c;
    c = 12'h000;
`ifdef VGA_TEST_PATTERN_EN
    if (!m_fresh && mh < int'(H_ACTIVE) && mv < int'(V_ACTIVE)) c = PAL[mh / 100];
`endif
    return mk(mh, mv, (mh >= 840 && mh <= 967), (mv >= 11 && mv <= 14),
              (mh >= 800), (mv >= 10), m_ls, m_fs, c);
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h ls=%b fs=%b; want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h ls=%b fs=%b",
               name, got.h, got.v, got.hs, got.vs, got.hb, got.vb, got.rgb, got.ls, got.fs,
               exp.h, exp.v, exp.hs, exp.vs, exp.hb, exp.vb, exp.rgb, exp.ls, exp.fs);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; m_ls = 1'b0; m_fs = 1'b0; m_fresh = 1'b1;
    sb_q.delete();
  endtask

  // Drive one cycle, push the expected result, then compare what the DUT presents
  task automatic step(input logic e, input logic r);
    obs_t exp;
    en_i = e;
    restart_i = r;
    if (r) begin
      mh = 0; mv = 0; m_ls = 1'b1; m_fs = 1'b1; m_fresh = 1'b0;
    end else if (e) begin
      mh++;
      if (mh == H_TOTAL) begin
        mh = 0;
        mv++;
        if (mv == V_TOTAL) mv = 0;
      end
      m_ls = (mh == 0);
      m_fs = (mh == 0) && (mv == 0);
      m_fresh = 1'b0;
    end else begin
      m_ls = 1'b0; m_fs = 1'b0;
    end
    sb_q.push_back(model_obs());
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check("scoreboard", dut_obs(), exp);
  endtask

  task automatic add(int cyc, logic e, logic r, obs_t o);
    vec_t t;
    t.cycles = cyc; t.en = e; t.rs = r; t.exp = o;
    vecs.push_back(t);
  endtask

  initial begin
    obs_t rst_val;
    rst_val = mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h000);

    //          cyc  en rs      h    v  hs vs hb vb ls fs rgb
    add(799,  1, 0, mk(799,  0, 0, 0, 0, 0, 0, 0, 12'h000));
    add(1,    1, 0, mk(800,  0, 0, 0, 1, 0, 0, 0, 12'h000));
    add(39,   1, 0, mk(839,  0, 0, 0, 1, 0, 0, 0, 12'h000));
    add(1,    1, 0, mk(840,  0, 1, 0, 1, 0, 0, 0, 12'h000));
    add(127,  1, 0, mk(967,  0, 1, 0, 1, 0, 0, 0, 12'h000));
    add(1,    1, 0, mk(968,  0, 0, 0, 1, 0, 0, 0, 12'h000));
    add(87,   1, 0, mk(1055, 0, 0, 0, 1, 0, 0, 0, 12'h000));
    add(1,    1, 0, mk(0,    1, 0, 0, 0, 0, 1, 0, 12'hFFF));
    add(500,  1, 0, mk(500,  1, 0, 0, 0, 0, 0, 0, 12'hF00));
    add(5,    0, 0, mk(500,  1, 0, 0, 0, 0, 0, 0, 12'hF00));
    add(1,    1, 0, mk(501,  1, 0, 0, 0, 0, 0, 0, 12'hF00));
    add(555,  1, 0, mk(0,    2, 0, 0, 0, 0, 1, 0, 12'hFFF));
    add(300,  1, 0, mk(300,  2, 0, 0, 0, 0, 0, 0, 12'h0F0));
    add(1,    0, 1, mk(0,    0, 0, 0, 0, 0, 1, 1, 12'hFFF));
    add(99,   1, 0, mk(99,   0, 0, 0, 0, 0, 0, 0, 12'hFFF));
    add(1,    1, 0, mk(100,  0, 0, 0, 0, 0, 0, 0, 12'hFF0));
    add(699,  1, 0, mk(799,  0, 0, 0, 0, 0, 0, 0, 12'h000));
    add(1,    1, 0, mk(800,  0, 0, 0, 1, 0, 0, 0, 12'h000));
    add(256,  1, 0, mk(0,    1, 0, 0, 0, 0, 1, 0, 12'hFFF));
    add(9504, 1, 0, mk(0,   10, 0, 0, 0, 1, 1, 0, 12'h000));
    add(1056, 1, 0, mk(0,   11, 0, 1, 0, 1, 1, 0, 12'h000));
    add(3168, 1, 0, mk(0,   14, 0, 1, 0, 1, 1, 0, 12'h000));
    add(1056, 1, 0, mk(0,   15, 0, 0, 0, 1, 1, 0, 12'h000));
    add(5279, 1, 0, mk(1055,19, 0, 0, 1, 1, 0, 0, 12'h000));
    add(1,    1, 0, mk(0,    0, 0, 0, 0, 0, 1, 1, 12'hFFF));

    rst_n = 1'b0; en_i = 1'b0; restart_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_values", dut_obs(), rst_val);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0);
    step(0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].cycles; c++) step(vecs[i].en, vecs[i].rs);
      check($sformatf("vec%0d", i), dut_obs(), vecs[i].exp);
    end

    // Asynchronous reset from inside the hsync/hblank region, no clock edge needed
    step(0, 1);
    for (int c = 0; c < 900; c++) step(1, 0);
    check("pre_async_reset", dut_obs(), mk(900, 0, 1, 0, 1, 0, 0, 0, 12'h000));
    rst_n = 1'b0;
    #2;
    check("async_reset", dut_obs(), rst_val);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0);
    check("first_en_after_reset", dut_obs(), mk(1, 0, 0, 0, 0, 0, 0, 0, 12'hFFF));

    // restart with en held high mid-line
    for (int c = 0; c < 20; c++) step(1, 0);
    step(1, 1);
    check("restart_with_en", dut_obs(), mk(0, 0, 0, 0, 0, 0, 1, 1, 12'hFFF));
    step(0, 0);
    check("hold_after_restart", dut_obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 12'hFFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
